// File: rtl/code_round_ctrl.sv
// code_round_ctrl: round sequencer for the code-breaking game.
// Collects four keypad digits, hands the guess to the comparator, tallies
// attempts on the LED bar and declares win/loss with a speaker trigger.
module code_round_ctrl #(
  parameter int MAX_ATTEMPTS = 8,
  parameter int CMP_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        send,
  input  logic        new_game,
  input  logic        cmp_valid,
  input  logic [2:0]  num_correct,
  output logic [15:0] guess,
  output logic [2:0]  digit_cnt,
  output logic        cmp_start,
  output logic [2:0]  last_score,
  output logic [7:0]  attempt_led,
  output logic        win,
  output logic        lose,
  output logic        snd_trig,
  output logic        entry_err
);
  typedef enum logic [2:0] {S_ENTRY, S_WAIT, S_JUDGE, S_WON, S_LOST} state_t;

  localparam logic [3:0] MAX_A    = 4'(MAX_ATTEMPTS);
  localparam logic [7:0] TMO_LAST = 8'(CMP_TIMEOUT - 1);

  state_t      state, state_nx;
  logic [3:0]  att_cnt, att_nx;
  logic [7:0]  tmo_cnt, tmo_nx;
  logic [15:0] guess_nx;
  logic [2:0]  dcnt_nx, score_nx;
  logic [7:0]  led_nx;
  logic        start_nx, win_nx, lose_nx, snd_nx, err_nx;

  // Register every output alongside the state so nothing downstream sees comb logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_ENTRY;
      att_cnt     <= '0;
      tmo_cnt     <= '0;
      guess       <= '0;
      digit_cnt   <= '0;
      cmp_start   <= 1'b0;
      last_score  <= '0;
      attempt_led <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
      snd_trig    <= 1'b0;
      entry_err   <= 1'b0;
    end else begin
      state       <= state_nx;
      att_cnt     <= att_nx;
      tmo_cnt     <= tmo_nx;
      guess       <= guess_nx;
      digit_cnt   <= dcnt_nx;
      cmp_start   <= start_nx;
      last_score  <= score_nx;
      attempt_led <= led_nx;
      win         <= win_nx;
      lose        <= lose_nx;
      snd_trig    <= snd_nx;
      entry_err   <= err_nx;
    end
  end

  // Next-state and next-output decode; strobes default low, levels hold.
  always_comb begin
    state_nx = state;
    att_nx   = att_cnt;
    tmo_nx   = tmo_cnt;
    guess_nx = guess;
    dcnt_nx  = digit_cnt;
    start_nx = 1'b0;
    score_nx = last_score;
    led_nx   = attempt_led;
    win_nx   = win;
    lose_nx  = lose;
    snd_nx   = 1'b0;
    err_nx   = 1'b0;
    if (new_game) begin
      state_nx = S_ENTRY;
      att_nx   = '0;
      tmo_nx   = '0;
      guess_nx = '0;
      dcnt_nx  = '0;
      score_nx = '0;
      led_nx   = '0;
      win_nx   = 1'b0;
      lose_nx  = 1'b0;
    end else begin
      case (state)
        S_ENTRY: begin
          // send outranks a coincident key, judged on the pre-edge count
          if (send) begin
            if (digit_cnt == 3'd4) begin
              state_nx = S_WAIT;
              start_nx = 1'b1;
              tmo_nx   = '0;
            end else begin
              err_nx = 1'b1;
            end
          end else if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (digit_cnt < 3'd4) begin
                guess_nx = {guess[11:0], key_code};
                dcnt_nx  = digit_cnt + 3'd1;
              end
            end else if (key_code == 4'hE) begin
              if (digit_cnt != 3'd0) begin
                guess_nx = guess >> 4;
                dcnt_nx  = digit_cnt - 3'd1;
              end
            end else if (key_code == 4'hF) begin
              guess_nx = '0;
              dcnt_nx  = '0;
            end
          end
        end
        S_WAIT: begin
          // a result on the timeout edge still counts
          if (cmp_valid) begin
            score_nx = (num_correct > 3'd4) ? 3'd0 : num_correct;
            state_nx = S_JUDGE;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_nx   = tmo_cnt + 8'd1;
            state_nx = S_ENTRY;
            err_nx   = 1'b1;
          end else begin
            tmo_nx = tmo_cnt + 8'd1;
          end
        end
        S_JUDGE: begin
          att_nx = att_cnt + 4'd1;
          led_nx = {attempt_led[6:0], 1'b1};
          if (last_score == 3'd4) begin
            state_nx = S_WON;
            win_nx   = 1'b1;
            snd_nx   = 1'b1;
          end else if (att_cnt + 4'd1 == MAX_A) begin
            state_nx = S_LOST;
            lose_nx  = 1'b1;
            snd_nx   = 1'b1;
          end else begin
            state_nx = S_ENTRY;
            guess_nx = '0;
            dcnt_nx  = '0;
          end
        end
        default: ; // WON / LOST hold until new_game
      endcase
    end
  end
endmodule

// File: tb/tb_code_round_ctrl.sv
// Directed bench for code_round_ctrl.
module tb_code_round_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, key_valid, send, new_game, cmp_valid;
  logic [3:0]  key_code;
  logic [2:0]  num_correct;
  logic [15:0] guess;
  logic [2:0]  digit_cnt, last_score;
  logic        cmp_start, win, lose, snd_trig, entry_err;
  logic [7:0]  attempt_led;
  int checks = 0;
  int errors = 0;

  code_round_ctrl #(.MAX_ATTEMPTS(8), .CMP_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .send(send), .new_game(new_game), .cmp_valid(cmp_valid),
    .num_correct(num_correct), .guess(guess), .digit_cnt(digit_cnt),
    .cmp_start(cmp_start), .last_score(last_score), .attempt_led(attempt_led),
    .win(win), .lose(lose), .snd_trig(snd_trig), .entry_err(entry_err));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1; key_code = k; tick(); key_valid = 1'b0;
  endtask

  task automatic do_send();
    send = 1'b1; tick(); send = 1'b0;
  endtask

  task automatic do_new_game();
    new_game = 1'b1; tick(); new_game = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #2;
    checks++;
    if ({guess, digit_cnt, cmp_start, last_score, attempt_led, win, lose, snd_trig, entry_err} !== 37'd0) begin
      errors++; $display("FAIL reset_outputs got guess=%h cnt=%0d led=%h win=%b lose=%b", guess, digit_cnt, attempt_led, win, lose);
    end
    tick(); #3 rst_n = 1'b1; tick();
  endtask

  task automatic test_entry();
    logic [3:0]  keys [6] = '{4'h1, 4'h9, 4'hD, 4'hE, 4'hF, 4'h3};
    logic [15:0] eg   [6] = '{16'h1, 16'h19, 16'h19, 16'h1, 16'h0, 16'h3};
    logic [2:0]  ec   [6] = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd0, 3'd1};
    for (int i = 0; i < 6; i++) begin
      press(keys[i]);
      checks++;
      if (guess !== eg[i] || digit_cnt !== ec[i]) begin
        errors++; $display("FAIL entry_key%0d got guess=%h cnt=%0d exp guess=%h cnt=%0d", i, guess, digit_cnt, eg[i], ec[i]);
      end
    end
    press(4'hE);
    checks++;
    if (guess !== 16'h0 || digit_cnt !== 3'd0) begin
      errors++; $display("FAIL entry_bksp_to_empty got guess=%h cnt=%0d", guess, digit_cnt);
    end
    press(4'hE); // backspace on empty does nothing
    checks++;
    if (guess !== 16'h0 || digit_cnt !== 3'd0) begin
      errors++; $display("FAIL entry_bksp_empty got guess=%h cnt=%0d", guess, digit_cnt);
    end
  endtask

  task automatic test_win();
    do_new_game();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    checks++;
    if (guess !== 16'h1234 || digit_cnt !== 3'd4) begin
      errors++; $display("FAIL win_fifth_digit got guess=%h cnt=%0d exp 1234/4", guess, digit_cnt);
    end
    do_send();
    checks++;
    if (cmp_start !== 1'b1) begin errors++; $display("FAIL win_start_hi got %b exp 1", cmp_start); end
    cmp_valid = 1'b1; num_correct = 3'd4; tick(); cmp_valid = 1'b0;
    checks++;
    if (cmp_start !== 1'b0 || last_score !== 3'd4 || attempt_led !== 8'h00 || win !== 1'b0) begin
      errors++; $display("FAIL win_judge_cycle got start=%b score=%0d led=%h win=%b", cmp_start, last_score, attempt_led, win);
    end
    tick();
    checks++;
    if (attempt_led !== 8'h01 || win !== 1'b1 || lose !== 1'b0 || snd_trig !== 1'b1) begin
      errors++; $display("FAIL win_result got led=%h win=%b lose=%b snd=%b exp 01/1/0/1", attempt_led, win, lose, snd_trig);
    end
    tick();
    checks++;
    if (snd_trig !== 1'b0 || win !== 1'b1) begin
      errors++; $display("FAIL win_snd_once got snd=%b win=%b exp 0/1", snd_trig, win);
    end
    // new_game from WON clears everything and reopens entry
    do_new_game();
    checks++;
    if (win !== 1'b0 || attempt_led !== 8'h00 || last_score !== 3'd0 || guess !== 16'h0) begin
      errors++; $display("FAIL newgame_won got win=%b led=%h score=%0d guess=%h", win, attempt_led, last_score, guess);
    end
    press(4'h7);
    checks++;
    if (guess !== 16'h7 || digit_cnt !== 3'd1) begin
      errors++; $display("FAIL newgame_entry got guess=%h cnt=%0d exp 7/1", guess, digit_cnt);
    end
  endtask

  task automatic test_lose();
    logic [7:0] exp_led;
    do_new_game();
    for (int i = 0; i < 8; i++) begin
      press(4'h5); press(4'h6); press(4'h7); press(4'h8);
      do_send();
      cmp_valid = 1'b1; num_correct = 3'd2; tick(); cmp_valid = 1'b0;
      tick();
      exp_led = 8'hFF >> (7 - i);
      checks++;
      if (attempt_led !== exp_led || win !== 1'b0 || lose !== (i == 7) || snd_trig !== (i == 7)) begin
        errors++; $display("FAIL lose_round%0d got led=%h lose=%b snd=%b exp led=%h", i, attempt_led, lose, snd_trig, exp_led);
      end
      if (i < 7) begin
        checks++;
        if (guess !== 16'h0 || digit_cnt !== 3'd0) begin
          errors++; $display("FAIL lose_clear%0d got guess=%h cnt=%0d", i, guess, digit_cnt);
        end
      end
    end
    tick();
    checks++;
    if (snd_trig !== 1'b0 || lose !== 1'b1) begin errors++; $display("FAIL lose_snd_once got snd=%b lose=%b", snd_trig, lose); end
    do_send();
    checks++;
    if (cmp_start !== 1'b0 || lose !== 1'b1 || attempt_led !== 8'hFF) begin
      errors++; $display("FAIL lose_send_ignored got start=%b lose=%b led=%h", cmp_start, lose, attempt_led);
    end
  endtask

  task automatic test_err_timeout();
    do_new_game();
    press(4'h1); press(4'h2); press(4'h3);
    key_valid = 1'b1; key_code = 4'h5; do_send(); key_valid = 1'b0;
    checks++;
    if (entry_err !== 1'b1 || cmp_start !== 1'b0 || digit_cnt !== 3'd3 || guess !== 16'h123) begin
      errors++; $display("FAIL err_short_send got err=%b start=%b cnt=%0d guess=%h", entry_err, cmp_start, digit_cnt, guess);
    end
    tick();
    checks++;
    if (entry_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width got %b exp 0", entry_err); end
    press(4'h8);
    do_send();
    repeat (14) tick();
    checks++;
    if (entry_err !== 1'b0) begin errors++; $display("FAIL tmo_early got err=%b exp 0", entry_err); end
    tick();
    checks++;
    if (entry_err !== 1'b1 || guess !== 16'h1238 || digit_cnt !== 3'd4 || attempt_led !== 8'h00) begin
      errors++; $display("FAIL tmo_fire got err=%b guess=%h cnt=%0d led=%h", entry_err, guess, digit_cnt, attempt_led);
    end
    tick();
    checks++;
    if (entry_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width got %b exp 0", entry_err); end
    // resubmit; result lands on the timeout edge and must win; score 7 reads as 0
    do_send();
    checks++;
    if (cmp_start !== 1'b1) begin errors++; $display("FAIL tmo_resend got start=%b exp 1", cmp_start); end
    repeat (14) tick();
    cmp_valid = 1'b1; num_correct = 3'd7; tick(); cmp_valid = 1'b0;
    checks++;
    if (entry_err !== 1'b0 || last_score !== 3'd0) begin
      errors++; $display("FAIL tmo_edge_valid got err=%b score=%0d exp 0/0", entry_err, last_score);
    end
    tick();
    checks++;
    if (attempt_led !== 8'h01 || win !== 1'b0 || digit_cnt !== 3'd0) begin
      errors++; $display("FAIL tmo_edge_judge got led=%h win=%b cnt=%0d", attempt_led, win, digit_cnt);
    end
  endtask

  task automatic test_rst_wait();
    do_new_game();
    press(4'h4); press(4'h3); press(4'h2); press(4'h1);
    do_send();
    tick();
    rst_n = 1'b0; #1;
    checks++;
    if (guess !== 16'h0 || digit_cnt !== 3'd0 || cmp_start !== 1'b0 || attempt_led !== 8'h0) begin
      errors++; $display("FAIL rst_wait_clear got guess=%h cnt=%0d start=%b", guess, digit_cnt, cmp_start);
    end
    #3 rst_n = 1'b1;
    tick();
    cmp_valid = 1'b1; num_correct = 3'd4; tick(); cmp_valid = 1'b0;
    tick(); tick();
    checks++;
    if (last_score !== 3'd0 || attempt_led !== 8'h00 || win !== 1'b0 || snd_trig !== 1'b0) begin
      errors++; $display("FAIL rst_late_valid got score=%0d led=%h win=%b", last_score, attempt_led, win);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; send = 1'b0;
    new_game = 1'b0; cmp_valid = 1'b0; num_correct = 3'd0;
    test_reset();
    test_entry();
    test_win();
    test_lose();
    test_err_timeout();
    test_rst_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/code_round_ctrl.md
# code_round_ctrl

Sequencing controller for the code-breaking game. Collects four keypad digits into a guess register, submits the guess to the digit comparator with a start/valid handshake, and counts attempts on the 8-LED bar. Declares win or loss and fires the speaker trigger. Sits between the keypad decoder / debounced `send` button on the input side and the comparator, LED bar, seven-segment mux and speaker on the output side.

## Interface
- `MAX_ATTEMPTS`, 8, attempts before loss (1..8)
- `CMP_TIMEOUT`, 15, cycles to wait for `cmp_valid` before abandoning a submission (1..255)

- `clk` in 1: system clock
- `rst_n` in 1: reset, asynchronous, active-low
- `key_valid` in 1: one-cycle strobe, keypad code ready
- `key_code` in 4: keypad code 0x0-0xF
- `send` in 1: one-cycle debounced submit strobe
- `new_game` in 1: one-cycle strobe, restart game
- `cmp_valid` in 1: comparator result strobe
- `num_correct` in 3: comparator score 0..4, valid with `cmp_valid`
- `guess` out 16: four BCD digits, most recent in [3:0]
- `digit_cnt` out 3: digits entered, 0..4
- `cmp_start` out 1: one-cycle comparator start
- `last_score` out 3: score of last judged guess
- `attempt_led` out 8: thermometer of attempts used
- `win` out 1: level, game won
- `lose` out 1: level, game lost
- `snd_trig` out 1: one-cycle speaker trigger
- `entry_err` out 1: one-cycle error strobe

## Operation
- States: ENTRY, WAIT, JUDGE, WON, LOST. Reset state ENTRY.
- Reset values: `guess`=0, `digit_cnt`=0, `cmp_start`=0, `last_score`=0, `attempt_led`=0, `win`=0, `lose`=0, `snd_trig`=0, `entry_err`=0, attempt counter=0, timeout counter=0.
- Priority: `rst_n` low > `new_game` > all other events.
- `new_game` in any state: return to ENTRY and load reset values for all outputs and counters.
- ENTRY, `key_valid`:
  - codes 0x0-0x9 with `digit_cnt`<4: `guess`<={guess[11:0],key_code}; `digit_cnt`++. At 4, further digits are ignored.
  - 0xE (backspace) with `digit_cnt`>0: `guess`<=guess>>4; `digit_cnt`--.
  - 0xF (clear): `guess`=0, `digit_cnt`=0.
  - 0xA-0xD: ignored.
- ENTRY, `send`:
  - `digit_cnt`==4: go to WAIT; `cmp_start`=1 for one cycle; `guess` frozen; timeout counter=0.
  - `digit_cnt`<4: `entry_err` pulse; stay in ENTRY.
- `send` and `key_valid` on the same edge in ENTRY: `send` is evaluated against the pre-edge `digit_cnt`; the key is dropped.
- WAIT: on `cmp_valid`: `last_score`<=`num_correct`; go to JUDGE. Otherwise the timeout counter increments each cycle. On reaching `CMP_TIMEOUT`: go to ENTRY, `entry_err` pulse, `guess`/`digit_cnt` retained, no attempt consumed. If `cmp_valid` arrives on the timeout edge, `cmp_valid` wins.
- JUDGE (one cycle): attempt counter++; `attempt_led`<={attempt_led[6:0],1'b1}. Then:
  - `last_score`==4: go to WON.
  - else attempt counter == `MAX_ATTEMPTS`: go to LOST.
  - else: go to ENTRY with `guess`=0, `digit_cnt`=0.
- WON: `win`=1. LOST: `lose`=1. Both hold until `new_game` or reset. `snd_trig` pulses once on entry to WON or LOST.
- `key_valid`, `send` and `cmp_valid` are ignored outside the states that consume them.
- `num_correct` values >4 are treated as 0.

## Timing
- All outputs are registered.
- `send` sampled at edge n → `cmp_start` high during cycle n..n+1 only.
- `cmp_valid` is legal from edge n+1 onward.
- `cmp_valid` at edge m → JUDGE during m..m+1. At edge m+1, `attempt_led` updates, and `win`/`lose` rise if applicable. `snd_trig` is high during m+1..m+2.
- Timeout: with no `cmp_valid`, ENTRY re-entered at edge n+`CMP_TIMEOUT`, and `entry_err` is high for that following cycle.
- `rst_n` falling clears all state immediately, mid-handshake included. A late `cmp_valid` arriving after reset is ignored.

## Test plan
- Keys 1,9,D,E,F,3: `guess` progresses 0x1, 0x19, 0x19 (D ignored), 0x1 (E backspace), 0x0 (F clear), 0x3 → `digit_cnt` 1,2,2,1,0,1.
- Enter 9,D?: enter 1,2,3,4, then 5 → `guess`=0x1234, `digit_cnt`=4. `send` → one-cycle `cmp_start`. `cmp_valid` with `num_correct`=4 → `attempt_led`=0x01, `win`=1, one `snd_trig` pulse.
- Eight full guesses each scored 2 → `attempt_led` steps 0x01..0xFF; after the 8th, `lose`=1 and `snd_trig` pulses. Further `send` is ignored.
- `send` with `digit_cnt`=3 → `entry_err` pulse, no `cmp_start`. Full guess with `cmp_valid` withheld 15 cycles → back to ENTRY, `entry_err` pulse, `guess` kept, `attempt_led` unchanged.
- `rst_n` low while in WAIT → all outputs 0 immediately. `cmp_valid` after release is ignored. `new_game` while in WON → `win`=0, `attempt_led`=0, ENTRY.
